// File: rtl/mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// Memory stage of the five-stage pipeline. Non-memory instructions pass straight
// through to the MEM/WB register. LDR/STR are carried out on an external 16-bit
// asynchronous SRAM as two half-word accesses (low half, then high half). Each
// half is held for SRAM_LAT cycles. While an access is in flight, ready is held
// low so the whole front of the pipeline freezes.
//
// Parameters
//   SRAM_LAT     cycles each half-word access is held (>= 1)
//   MEM_BASE     byte address subtracted from alu_res_in to form the SRAM address
//
// Ports
//   clk, rst     pipeline clock; asynchronous active-high reset
//   wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_rm_in, dest_in
//                execute-stage result bundle from the EXE/MEM register
//   wb_en_out, mem_r_en_out, alu_res_out, dest_out
//                combinational pass-through to the MEM/WB register
//   mem_data     registered load result
//   ready        0 = freeze the pipeline
//   sram_addr    half-word address
//   sram_dq_out  write data
//   sram_dq_in   read data
//   sram_dq_oe   1 = this block drives the SRAM data bus
//   sram_we_n    active-low write strobe
// -----------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
   parameter int unsigned SRAM_LAT = 2,
   parameter int unsigned MEM_BASE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic [31:0] alu_res_in,
   input  logic [31:0] val_rm_in,
   input  logic [3:0]  dest_in,
   output logic        wb_en_out,
   output logic        mem_r_en_out,
   output logic [31:0] alu_res_out,
   output logic [3:0]  dest_out,
   output logic [31:0] mem_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);

   localparam int unsigned CntW = $clog2(SRAM_LAT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(SRAM_LAT - 1);

   typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [16:0]     word_q;      // word address, bits [18:2] of the offset
   logic [31:0]     wdata_q;
   logic            wr_q;
   logic [31:0]     mem_data_q;

   logic        req;
   logic [31:0] offset;
   logic        capture, latch_lo, latch_hi;
   logic        unused_offset_bits;

   assign req    = mem_r_en_in | mem_w_en_in;
   assign offset = alu_res_in - MEM_BASE;

   // Byte-lane bits and everything above the 512 KB window are don't-care.
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

   assign wb_en_out    = wb_en_in;
   assign mem_r_en_out = mem_r_en_in;
   assign alu_res_out  = alu_res_in;
   assign dest_out     = dest_in;
   assign mem_data     = mem_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         word_q     <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         mem_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            word_q  <= offset[18:2];
            wdata_q <= val_rm_in;
            wr_q    <= mem_w_en_in;   // write wins when both enables are set
         end
         if (latch_lo) mem_data_q[15:0]  <= sram_dq_in;
         if (latch_hi) mem_data_q[31:16] <= sram_dq_in;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      capture     = 1'b0;
      latch_lo    = 1'b0;
      latch_hi    = 1'b0;
      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;

      unique case (state_q)
         StIdle: begin
            ready = ~req;
            if (req) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = StLo;
            end
         end
         StLo: begin
            sram_addr = {word_q, 1'b0};
            if (wr_q) begin
               sram_dq_out = wdata_q[15:0];
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
            end
            if (cnt_q == CntLast) begin
               latch_lo = ~wr_q;
               cnt_d    = '0;
               state_d  = StHi;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StHi: begin
            sram_addr = {word_q, 1'b1};
            if (wr_q) begin
               sram_dq_out = wdata_q[31:16];
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
            end
            if (cnt_q == CntLast) begin
               latch_hi = ~wr_q;
               cnt_d    = '0;
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            // Pipeline advances at this edge; the held request is not re-seen.
            ready   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
//
// Bench for mem_stage_sram_ctrl. A driver issues directed and random instructions
// and pushes the expected per-instruction behaviour into a scoreboard queue. A
// monitor walks the DUT cycle by cycle and compares. The expected load data comes
// from a word-level memory model, and the SRAM itself is a half-word array device.
// -----------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

   localparam int unsigned LAT   = 2;
   localparam int unsigned BASE  = 1024;
   localparam int          TOTAL = 2 * LAT + 2;

   logic        clk, rst;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [31:0] alu_res_in, val_rm_in;
   logic [3:0]  dest_in;
   logic        wb_en_out, mem_r_en_out;
   logic [31:0] alu_res_out;
   logic [3:0]  dest_out;
   logic [31:0] mem_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   mem_stage_sram_ctrl #(
      .SRAM_LAT (LAT),
      .MEM_BASE (BASE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_en_in     (wb_en_in),
      .mem_r_en_in  (mem_r_en_in),
      .mem_w_en_in  (mem_w_en_in),
      .alu_res_in   (alu_res_in),
      .val_rm_in    (val_rm_in),
      .dest_in      (dest_in),
      .wb_en_out    (wb_en_out),
      .mem_r_en_out (mem_r_en_out),
      .alu_res_out  (alu_res_out),
      .dest_out     (dest_out),
      .mem_data     (mem_data),
      .ready        (ready),
      .sram_addr    (sram_addr),
      .sram_dq_out  (sram_dq_out),
      .sram_dq_in   (sram_dq_in),
      .sram_dq_oe   (sram_dq_oe),
      .sram_we_n    (sram_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous SRAM device: half-word array, write on strobe, read settled
   // well before the controller's latching edge.
   logic [15:0] dev [0:262143];
   initial for (int i = 0; i < 262144; i++) dev[i] = 16'h0;
   always @(posedge clk) if (!sram_we_n) dev[sram_addr] <= sram_dq_out;
   always @(negedge clk) sram_dq_in <= dev[sram_addr];

   typedef struct packed {
      logic        mem;
      logic        st;
      logic [17:0] lo;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        wb;
      logic        rd;
      logic [31:0] alu;
      logic [3:0]  dest;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] last_load;
   logic        active, mon_en, abort;
   int          n_chk, n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: actual event required none at %0t", name, $time);
   endtask

   // Starts at a negedge, returns at the posedge where the instruction retires.
   task automatic issue(input logic r, input logic w, input logic [31:0] alu,
                        input logic [31:0] val, input logic [3:0] dest, input logic wb);
      exp_t        e;
      int unsigned widx;
      logic        rdy;
      int          n;
      widx       = ((alu - BASE) / 4) % 131072;
      e.mem      = r | w;
      e.st       = w;
      e.lo       = 18'(widx * 2);
      e.wdata    = val;
      e.wb       = wb;
      e.rd       = r;
      e.alu      = alu;
      e.dest     = dest;
      if (w) begin
         ref_mem[widx] = val;
         e.exp_data    = last_load;
      end else if (r) begin
         last_load  = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
         e.exp_data = last_load;
      end else begin
         e.exp_data = last_load;
      end
      sb.push_back(e);
      mem_r_en_in = r;
      mem_w_en_in = w;
      alu_res_in  = alu;
      val_rm_in   = val;
      dest_in     = dest;
      wb_en_in    = wb;
      active      = 1'b1;
      mon_en      = 1'b1;
      n = 0;
      forever begin
         #2 rdy = ready;
         @(posedge clk);
         if (rdy) break;
         n++;
         if (n > TOTAL + 4) begin
            fail_now("issue_timeout");
            abort = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      active      = 1'b0;
      mem_r_en_in = 1'b0;
      mem_w_en_in = 1'b0;
      alu_res_in  = $urandom();
      val_rm_in   = $urandom();
      dest_in     = 4'($urandom_range(0, 15));
      wb_en_in    = 1'($urandom_range(0, 1));
      @(posedge clk);
   endtask

   // Monitor: one sample per cycle, in the low phase after the driver settles.
   initial begin : monitor
      int   cyc;
      int   total;
      exp_t e;
      logic exp_we, in_acc;
      cyc = 0;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            if (!active) begin
               chk("idle_ready", ready, 1);
               chk("idle_we_n", sram_we_n, 1);
               chk("idle_oe", sram_dq_oe, 0);
            end else if (sb.size() == 0) begin
               fail_now("scoreboard_empty");
            end else begin
               e      = sb[0];
               total  = e.mem ? TOTAL : 1;
               in_acc = e.mem && cyc >= 1 && cyc <= 2 * LAT;
               exp_we = e.st && in_acc;
               chk("ready", ready, 32'(cyc == total - 1));
               chk("sram_we_n", sram_we_n, 32'(!exp_we));
               chk("sram_dq_oe", sram_dq_oe, 32'(exp_we));
               if (in_acc) chk("sram_addr", sram_addr, (cyc <= LAT) ? e.lo : e.lo + 1);
               if (exp_we)
                  chk("sram_dq_out", sram_dq_out,
                      (cyc <= LAT) ? e.wdata[15:0] : e.wdata[31:16]);
               chk("wb_en_out", wb_en_out, e.wb);
               chk("mem_r_en_out", mem_r_en_out, e.rd);
               chk("alu_res_out", alu_res_out, e.alu);
               chk("dest_out", dest_out, e.dest);
               if (ready) begin
                  chk("mem_data", mem_data, e.exp_data);
                  void'(sb.pop_front());
                  cyc = 0;
               end else begin
                  cyc++;
                  if (cyc > total + 4) begin
                     fail_now("no_retire");
                     void'(sb.pop_front());
                     cyc = 0;
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: actual still running required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic r, w;
      logic [31:0] alu;
      n_chk = 0;
      n_fail = 0;
      last_load = 32'h0;
      active = 1'b0;
      mon_en = 1'b0;
      abort  = 1'b0;
      rst         = 1'b1;
      wb_en_in    = 1'b0;
      mem_r_en_in = 1'b0;
      mem_w_en_in = 1'b1;
      alu_res_in  = BASE + 400;
      val_rm_in   = 32'hA5A5_5A5A;
      dest_in     = 4'd2;

      repeat (2) @(negedge clk);
      #2;
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_oe", sram_dq_oe, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_dq_out", sram_dq_out, 0);
      chk("rst_ready_req", ready, 0);

      // Release with the store request held: it must start on the first edge.
      @(negedge clk);
      rst = 1'b0;
      issue(1'b0, 1'b1, BASE + 400, 32'hA5A5_5A5A, 4'd2, 1'b0);

      @(negedge clk); issue(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd1, 1'b0);
      @(negedge clk); issue(1'b1, 1'b0, 32'd1028, 32'h0, 4'd3, 1'b1);
      @(negedge clk); issue(1'b0, 1'b0, 32'h55, 32'h0, 4'd7, 1'b1);
      @(negedge clk); issue(1'b0, 1'b1, 32'd1024, 32'h1234_5678, 4'd4, 1'b0);
      @(negedge clk); issue(1'b1, 1'b0, 32'd1024, 32'h0, 4'd5, 1'b1);
      @(negedge clk); issue(1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, 4'd6, 1'b1);
      @(negedge clk); issue(1'b1, 1'b0, 32'd1032, 32'h0, 4'd6, 1'b1);

      for (int i = 0; i < 200 && !abort; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 4) == 0) begin
            idle();
         end else begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
               0:       alu = $urandom();
               1:       alu = BASE + ($urandom_range(0, 15) << 2) + ($urandom_range(1, 7) << 19)
                              + $urandom_range(0, 3);
               default: alu = BASE + ($urandom_range(0, 15) << 2);
            endcase
            issue(r, w, alu, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         end
      end

      if (!abort) begin
         // Reset in the middle of the high half of a store.
         @(negedge clk);
         mon_en      = 1'b0;
         active      = 1'b0;
         mem_r_en_in = 1'b0;
         mem_w_en_in = 1'b1;
         alu_res_in  = BASE + 800;
         val_rm_in   = 32'hCAFE_F00D;
         repeat (3) @(posedge clk);
         @(negedge clk);
         #2;
         chk("hi_we_n", sram_we_n, 0);
         chk("hi_addr", sram_addr, 401);
         rst = 1'b1;
         #1;
         chk("rst_hi_we_n", sram_we_n, 1);
         chk("rst_hi_oe", sram_dq_oe, 0);
         chk("rst_hi_ready_req", ready, 0);
         mem_w_en_in = 1'b0;
         #1;
         chk("rst_hi_ready", ready, 1);
         chk("rst_hi_mem_data", mem_data, 0);
         @(negedge clk);
         rst = 1'b0;
         repeat (2) begin
            @(negedge clk);
            #2;
            chk("post_rst_ready", ready, 1);
            chk("post_rst_we_n", sram_we_n, 1);
         end
         chk("no_hi_write", dev[401], 0);
         chk("lo_written", dev[400], 32'hF00D);
      end

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory stage of the five-stage ARM pipeline. It consumes the execute stage's result bundle (ALU result as address, Rm value as store data, memory enables, write-back enable, destination) and performs LDR/STR through an external 16-bit asynchronous SRAM, two half-word accesses per 32-bit word. While an access is in flight it drives `ready` low, so the hazard/freeze logic stalls every upstream stage and the EXE/MEM register. Non-memory instructions pass through with zero added latency.

## Interface
- `SRAM_LAT`, default 2: cycles each half-word SRAM access is held (≥1).
- `MEM_BASE`, default 1024: byte address subtracted from `alu_res` to form the SRAM address.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in` in 1 each: control from the EXE/MEM register.
- `alu_res_in` in 32: effective byte address, or ALU result for non-memory instructions.
- `val_rm_in` in 32: store data.
- `dest_in` in 4: destination register.
- `wb_en_out`, `mem_r_en_out`, `alu_res_out`, `dest_out` out 1/1/32/4: combinational pass-through to the MEM/WB register.
- `mem_data` out 32: load result, registered.
- `ready` out 1: 0 means freeze the pipeline.
- `sram_addr` out 18: half-word address.
- `sram_dq_out` out 16: write data.
- `sram_dq_in` in 16: read data.
- `sram_dq_oe` out 1: 1 means the block drives the SRAM bus.
- `sram_we_n` out 1: active-low write strobe.

## Operation
- `req = mem_r_en_in | mem_w_en_in`.
- FSM states: IDLE, LO, HI, DONE.
- IDLE with `req=0`:
  - stays IDLE, `ready=1`;
  - `sram_we_n=1`, `sram_dq_oe=0`.
- IDLE with `req=1`:
  - `ready=0`;
  - at the clock edge, captures `a = alu_res_in - MEM_BASE` (32-bit wrap), `val_rm_in`, and `wr = mem_w_en_in` (write has priority if both enables are set);
  - clears the cycle counter and moves to LO.
- LO, held SRAM_LAT cycles:
  - `sram_addr = {a[18:2], 1'b0}`;
  - on a write: `sram_dq_out = data[15:0]`, `sram_dq_oe=1`, `sram_we_n=0`;
  - on a read: `sram_we_n=1`, `sram_dq_oe=0`, and `sram_dq_in` is latched into `rd_lo` on the last LO cycle;
  - then moves to HI.
- HI, held SRAM_LAT cycles:
  - same as LO with `sram_addr = {a[18:2], 1'b1}` and `data[31:16]`;
  - on a read, the last HI cycle latches `sram_dq_in` into `rd_hi`;
  - then moves to DONE.
- DONE, one cycle:
  - `ready=1` and `sram_we_n=1`;
  - `mem_data` already holds `{rd_hi, rd_lo}` for a read, and is unchanged for a write;
  - the pipeline advances at this edge; next state is IDLE unconditionally.
- `ready` is 1 in IDLE&~req and in DONE, and 0 otherwise. It is combinational from state and `req`.
- Captured operands drive the access. If `req` drops mid-access, the access still completes and `ready` stays 0 until DONE. There is no abort.
- Address bits [1:0] are ignored (word-aligned only). Bits above 18 are ignored, so addresses wrap modulo 512 KB.
- The counter is `$clog2(SRAM_LAT+1)` bits wide and resets to 0 on every LO/HI entry.

## Timing
- Reset values:
  - state=IDLE, counter=0;
  - `mem_data=0`, `sram_addr=0`, `sram_dq_out=0`;
  - `sram_dq_oe=0`, `sram_we_n=1`;
  - `ready=1` when `req=0`.
- Reset mid-access: the FSM goes to IDLE immediately (asynchronous). `sram_we_n` deasserts with no write completion.
- A memory instruction occupies MEM for 2·SRAM_LAT+2 cycles: 6 at default, with `ready=0` for 5 of them.
- A non-memory instruction occupies 1 cycle with `ready=1`.
- `mem_data` is updated at the last LO/HI edges. It is stable from the DONE cycle until the next load's last LO edge.
- `sram_addr` and `sram_dq_out` are stable for the full `sram_we_n=0` window. The write strobe never spans two addresses.
- Back-to-back memory instructions: DONE→IDLE costs one cycle. The next instruction's `req` is seen in IDLE, so there is no bubble beyond the FSM latency.

## Test plan
- Reset: `rst=1` for 2 cycles with `mem_w_en_in=1` → `sram_we_n=1`, `sram_dq_oe=0`, `mem_data=0`. After release, the FSM leaves IDLE on the first edge.
- Store: `alu_res_in=1028`, `val_rm_in=0xDEADBEEF`, `mem_w_en_in=1` →
  - `ready=0` for 5 cycles;
  - `sram_addr=2` with `sram_dq_out=0xBEEF`, `sram_we_n=0` for 2 cycles;
  - then `sram_addr=3` with `sram_dq_out=0xDEAD` for 2 cycles;
  - `ready=1` in cycle 6.
- Load: SRAM model holds addr 2 = 0xBEEF and addr 3 = 0xDEAD; `alu_res_in=1028`, `mem_r_en_in=1` → `mem_data=0xDEADBEEF` in the DONE cycle; `sram_dq_oe=0` throughout.
- Pass-through: `mem_r_en_in=mem_w_en_in=0`, `alu_res_in=0x55`, `dest_in=7`, `wb_en_in=1` → `ready=1` the same cycle, outputs equal inputs, no SRAM strobes.
- Back-to-back: STR 1024←0x12345678 followed by LDR 1024 → the second operation starts the cycle after DONE; `mem_data=0x12345678`; total 12 cycles.
- Reset during HI of a store → `sram_we_n=1` in the same cycle, `ready=1` once `req=0`, and the FSM is back in IDLE.
